// File: rtl/vec_mul8_array_seq.sv
// SEW-aware vector multiplier: NUM_MUL8 shared 8x8 unsigned multipliers run one
// pass per cycle and accumulate shifted byte partials into per-lane 2*SEW products.
module vec_mul8_array_seq #(
  parameter int DATA_W   = 32,
  parameter int NUM_MUL8 = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   data_in_A,
  input  logic [DATA_W-1:0]   data_in_B,
  input  logic [1:0]          sew,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*DATA_W-1:0] result,
  output logic                sew_err
);

  localparam int RES_W  = 2 * DATA_W;
  localparam int NBYTES = DATA_W / 8;
  localparam int BIDX_W = $clog2(NBYTES);
  localparam int CNT_W  = $clog2(DATA_W);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  a_q, b_q;
  logic [1:0]         sew_q;
  logic [RES_W-1:0]   acc_q, result_q, pass_sum;
  logic [CNT_W-1:0]   pass_cnt;
  logic               sew_err_q;
  logic               accept, last_pass, sew_illegal;

  assign sew_illegal = (sew_q == 2'b11);

  // One pass of the multiplier array. Partial k is lane-major, then A byte i,
  // then B byte j; each lands at its lane base plus 8*(i+j). A lane's running
  // sum never exceeds its final product, so a single wide adder never carries
  // across a lane boundary.
  always_comb begin
    int total, passes, k, lane, bi, bj;
    logic [BIDX_W-1:0] a_idx, b_idx;
    logic [15:0]       prod;
    // NOTE: every always_comb variable gets a value before any branch so no latch is inferred.
    pass_sum = acc_q;
    total    = NBYTES << sew_q;
    passes   = (total > NUM_MUL8) ? total / NUM_MUL8 : 1;
    k        = 0;
    lane     = 0;
    bi       = 0;
    bj       = 0;
    a_idx    = '0;
    b_idx    = '0;
    prod     = '0;
    for (int m = 0; m < NUM_MUL8; m++) begin
      k     = int'(pass_cnt) * NUM_MUL8 + m;
      lane  = k >> (2 * sew_q);
      bi    = (k >> sew_q) & ((1 << sew_q) - 1);
      bj    = k & ((1 << sew_q) - 1);
      a_idx = BIDX_W'((lane << sew_q) + bi);
      b_idx = BIDX_W'((lane << sew_q) + bj);
      prod  = a_q[{a_idx, 3'b000} +: 8] * b_q[{b_idx, 3'b000} +: 8];
      if (k < total) begin
        pass_sum = pass_sum + (RES_W'(prod) << ((lane << (sew_q + 4)) + 8 * (bi + bj)));
      end
    end
    last_pass = (int'(pass_cnt) == passes - 1);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = ~reset;
        accept   = in_valid & ~reset;
        if (accept) state_d = CALC;
      end
      CALC: begin
        if (sew_illegal || last_pass) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the asynchronous reset clears every datapath register, so an aborted
  // transaction leaves no trace on result or sew_err.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q       <= '0;
      b_q       <= '0;
      sew_q     <= '0;
      acc_q     <= '0;
      pass_cnt  <= '0;
      result_q  <= '0;
      sew_err_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_q      <= data_in_A;
            b_q      <= data_in_B;
            sew_q    <= sew;
            acc_q    <= '0;
            pass_cnt <= '0;
          end
        end
        CALC: begin
          if (sew_illegal) begin
            result_q  <= '0;
            sew_err_q <= 1'b1;
          end else if (last_pass) begin
            result_q  <= pass_sum;
            sew_err_q <= 1'b0;
          end else begin
            acc_q    <= pass_sum;
            pass_cnt <= pass_cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) sew_err_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign result  = result_q;
  assign sew_err = sew_err_q;

endmodule

// File: tb/tb_vec_mul8_array_seq.sv
// Directed bench for vec_mul8_array_seq (DATA_W=32, NUM_MUL8=8): hand-computed
// products, latency, backpressure, mid-operation reset and illegal sew.
module tb_vec_mul8_array_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] data_in_A;
  logic [31:0] data_in_B;
  logic [1:0]  sew;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;
  logic        sew_err;

  int checks = 0;
  int errors = 0;

  vec_mul8_array_seq #(.DATA_W(32), .NUM_MUL8(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in_A (data_in_A),
    .data_in_B (data_in_B),
    .sew       (sew),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .sew_err   (sew_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one transaction with out_ready high and check latency, value and handshake.
  task automatic run_txn(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] s, input logic [63:0] exp_res,
                         input logic exp_err, input int exp_lat);
    int lat;
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    data_in_A = a;
    data_in_B = b;
    sew       = s;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick;
    in_valid  = 1'b0;
    data_in_A = ~a;
    data_in_B = ~b;
    lat = 0;
    while (!out_valid && lat < 16) begin
      tick;
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_result"}, result, exp_res);
    check({tag, "_sew_err"}, 64'(sew_err), 64'(exp_err));
    check({tag, "_busy"}, 64'(in_ready), 64'd0);
    tick;
    check({tag, "_out_valid_clr"}, 64'(out_valid), 64'd0);
    check({tag, "_sew_err_clr"}, 64'(sew_err), 64'd0);
    check({tag, "_in_ready_back"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    int lat;
    logic seen;

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    data_in_A = '0;
    data_in_B = '0;
    sew       = 2'b00;

    #12;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", result, 64'd0);
    check("rst_sew_err", 64'(sew_err), 64'd0);
    tick;
    reset = 1'b0;
    #1;
    check("rel_in_ready", 64'(in_ready), 64'd1);
    tick;

    run_txn("sew8",      32'h11223344, 32'hAABBCCDD, 2'b00, 64'h0B4A18D6_28A43AB4, 1'b0, 1);
    run_txn("sew16",     32'h11223344, 32'hAABBCCDD, 2'b01, 64'h0B6D17D6_290671B4, 1'b0, 1);
    run_txn("sew32_max", 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b10, 64'hFFFFFFFE_00000001, 1'b0, 2);
    run_txn("sew8_max",  32'hFFFFFFFF, 32'hFFFFFFFF, 2'b00, 64'hFE01FE01_FE01FE01, 1'b0, 1);
    run_txn("sew16_max", 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b01, 64'hFFFE0001_FFFE0001, 1'b0, 1);
    run_txn("sew32_pow", 32'h00000002, 32'h80000000, 2'b10, 64'h00000001_00000000, 1'b0, 2);

    // Backpressure: result held, new in_valid ignored until after the handshake.
    out_ready = 1'b0;
    data_in_A = 32'h11223344;
    data_in_B = 32'hAABBCCDD;
    sew       = 2'b00;
    in_valid  = 1'b1;
    tick;
    data_in_A = 32'hDEADBEEF;
    data_in_B = 32'h01020304;
    sew       = 2'b10;
    lat = 0;
    while (!out_valid && lat < 16) begin
      tick;
      lat++;
    end
    check("bp_latency", 64'(lat), 64'd1);
    for (int c = 0; c < 3; c++) begin
      tick;
      check($sformatf("bp_hold%0d_result", c), result, 64'h0B4A18D6_28A43AB4);
      check($sformatf("bp_hold%0d_valid", c), 64'(out_valid), 64'd1);
      check($sformatf("bp_hold%0d_in_ready", c), 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    tick;
    in_valid = 1'b0;
    check("bp_out_valid_clr", 64'(out_valid), 64'd0);
    check("bp_in_ready_back", 64'(in_ready), 64'd1);
    seen = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick;
      seen = seen | out_valid | ~in_ready;
    end
    check("bp_no_ghost_txn", 64'(seen), 64'd0);

    // Reset pulse during CALC of a two-pass transaction.
    data_in_A = 32'hFFFFFFFF;
    data_in_B = 32'hFFFFFFFF;
    sew       = 2'b10;
    in_valid  = 1'b1;
    tick;
    in_valid = 1'b0;
    reset    = 1'b1;
    #1;
    check("mid_rst_result", result, 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd0);
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    tick;
    tick;
    reset = 1'b0;
    #1;
    check("mid_rel_in_ready", 64'(in_ready), 64'd1);
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick;
      seen = seen | out_valid;
    end
    check("mid_no_output", 64'(seen), 64'd0);
    check("mid_result_zero", result, 64'd0);
    run_txn("post_rst_sew8", 32'h11223344, 32'hAABBCCDD, 2'b00, 64'h0B4A18D6_28A43AB4, 1'b0, 1);

    run_txn("sew_illegal", 32'h11223344, 32'hAABBCCDD, 2'b11, 64'd0, 1'b1, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
